line_3_buffer_ctrl: RTL and testbench

Sequencing controller for the 3-row line buffer in the conv front end. It runs one frame of H rows:
- clears the line buffer at frame start;
- admits rows from upstream through a valid/ready handshake, spaced by a programmable gap that covers downstream window-consumer latency;
- flags each complete 3-row window with its row index and slot rotation.

The row data itself bypasses the controller, going upstream → line buffer directly.

---
 rtl/line_3_buffer_ctrl.sv | 155 +++++++++++++++
 tb/tb_line_3_buffer_ctrl.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/line_3_buffer_ctrl.sv
// Frame sequencer for the 3-row line buffer: clear, admit H rows spaced by GAP, flag 3-row windows.
// Latency: lb_valid_o same cycle as transfer; win_valid_o / done_o one cycle after the transfer.
// Backpressure: row_ready_o only in LOAD; upstream may hold off indefinitely, no row lost or duplicated.
// Optional feature: define LB_CTRL_ABORT_EN to add abort_i (frame abort back to IDLE with buffer clear).
module line_3_buffer_ctrl #(
    parameter int H   = 24,
    parameter int GAP = 4
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       start,
    input  logic       row_valid_i,
`ifdef LB_CTRL_ABORT_EN
    input  logic       abort_i,
`endif
    output logic       row_ready_o,
    output logic       lb_valid_o,
    output logic       lb_resetn_o,
    output logic       win_valid_o,
    output logic [7:0] win_row_o,
    output logic [1:0] rot_o,
    output logic       busy_o,
    output logic       done_o
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLEAR = 3'd1,
        LOAD  = 3'd2,
        WAIT  = 3'd3,
        DONE  = 3'd4
    } state_t;

    localparam logic [7:0] H_LAST   = 8'(H);
    localparam logic [3:0] GAP_LOAD = 4'(GAP - 1);

    state_t     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic [3:0] gap_q, gap_d;
    logic [1:0] rot_q, rot_d;
    logic       win_vld_q, win_vld_d;
    logic [7:0] win_row_q, win_row_d;
    logic       done_q, done_d;
    logic       lbrst_q, lbrst_d;

    logic       abort;
    logic       xfer;
    logic [7:0] cnt_inc;

`ifdef LB_CTRL_ABORT_EN
    // Abort only matters while a frame is actively sequencing rows.
    assign abort = abort_i && (state_q == CLEAR || state_q == LOAD || state_q == WAIT);
`else
    assign abort = 1'b0;
`endif

    // Abort suppresses ready so a colliding row is never written.
    assign row_ready_o = (state_q == LOAD) && !abort;
    assign xfer        = row_valid_i && row_ready_o;
    assign lb_valid_o  = xfer;
    assign cnt_inc     = cnt_q + 8'd1;

    assign lb_resetn_o = lbrst_q;
    assign win_valid_o = win_vld_q;
    assign win_row_o   = win_row_q;
    assign rot_o       = rot_q;
    assign busy_o      = (state_q != IDLE);
    assign done_o      = done_q;

    // Next-state and registered-output logic for the frame sequencer.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        gap_d     = gap_q;
        rot_d     = rot_q;
        win_vld_d = 1'b0;
        win_row_d = win_row_q;
        done_d    = 1'b0;
        lbrst_d   = 1'b1;
        case (state_q)
            IDLE: begin
                if (start) begin
                    // Clear strobe and counter reset land on the same edge we enter CLEAR.
                    state_d = CLEAR;
                    lbrst_d = 1'b0;
                    cnt_d   = 8'd0;
                    rot_d   = 2'd0;
                end
            end
            CLEAR: begin
                state_d = LOAD;
            end
            LOAD: begin
                if (xfer) begin
                    cnt_d = cnt_inc;
                    rot_d = (rot_q == 2'd2) ? 2'd0 : rot_q + 2'd1;
                    if (cnt_inc >= 8'd3) begin
                        win_vld_d = 1'b1;
                        win_row_d = cnt_inc - 8'd3;
                    end
                    if (cnt_inc == H_LAST) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = WAIT;
                        gap_d   = GAP_LOAD;
                    end
                end
            end
            WAIT: begin
                if (gap_q == 4'd0) begin
                    state_d = LOAD;
                end else begin
                    gap_d = gap_q - 4'd1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        if (abort) begin
            state_d   = IDLE;
            lbrst_d   = 1'b0;
            win_vld_d = 1'b0;
            done_d    = 1'b0;
        end
    end

    // State register; the line-buffer clear is held asserted throughout reset.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= IDLE;
            cnt_q     <= 8'd0;
            gap_q     <= 4'd0;
            rot_q     <= 2'd0;
            win_vld_q <= 1'b0;
            win_row_q <= 8'd0;
            done_q    <= 1'b0;
            lbrst_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            gap_q     <= gap_d;
            rot_q     <= rot_d;
            win_vld_q <= win_vld_d;
            win_row_q <= win_row_d;
            done_q    <= done_d;
            lbrst_q   <= lbrst_d;
        end
    end

endmodule

// File: tb/tb_line_3_buffer_ctrl.sv
// Bench for line_3_buffer_ctrl with H=5, GAP=2.
// Expected transfer/window/done events are queued up front and popped as the DUT emits them.
// Inputs change on the falling edge; outputs are sampled 1 time unit later.
module tb_line_3_buffer_ctrl;

    localparam int H   = 5;
    localparam int GAP = 2;

    logic       clk = 1'b0;
    logic       resetn;
    logic       start;
    logic       row_valid_i;
    logic       abort_i;
    logic       row_ready_o;
    logic       lb_valid_o;
    logic       lb_resetn_o;
    logic       win_valid_o;
    logic [7:0] win_row_o;
    logic [1:0] rot_o;
    logic       busy_o;
    logic       done_o;

    int total = 0;
    int bad   = 0;

    int exp_xfer[$];
    int exp_xrot[$];
    int exp_win_rel[$];
    int exp_win_row[$];
    int exp_win_rot[$];
    int exp_done[$];

    logic busy_at [64];
    logic lbr_at  [64];
    logic rdy_at  [64];

    line_3_buffer_ctrl #(.H(H), .GAP(GAP)) dut (
        .clk         (clk),
        .resetn      (resetn),
        .start       (start),
        .row_valid_i (row_valid_i),
`ifdef LB_CTRL_ABORT_EN
        .abort_i     (abort_i),
`endif
        .row_ready_o (row_ready_o),
        .lb_valid_o  (lb_valid_o),
        .lb_resetn_o (lb_resetn_o),
        .win_valid_o (win_valid_o),
        .win_row_o   (win_row_o),
        .rot_o       (rot_o),
        .busy_o      (busy_o),
        .done_o      (done_o)
    );

    always #5 clk = ~clk;

    // Frame engine: start at relative cycle 0, drive valid/start/abort, pop the scoreboard on every output event.
    task automatic run_frame(input string tag, input int ncyc, input int stall_from, input int stall_len,
                             input int extra_start, input int abort_at);
        int e, er, eo;
        for (int r = 0; r < ncyc; r++) begin
            start       = (r == 0) || (r == extra_start);
            row_valid_i = !(r >= stall_from && r < stall_from + stall_len);
            abort_i     = (r == abort_at);
            #1;
            busy_at[r] = busy_o;
            lbr_at[r]  = lb_resetn_o;
            rdy_at[r]  = row_ready_o;
            if (lb_valid_o) begin
                total++;
                if (exp_xfer.size() == 0) begin
                    bad++;
                    $display("FAIL %s xfer: unexpected transfer at cycle %0d", tag, r);
                end else begin
                    e  = exp_xfer.pop_front();
                    eo = exp_xrot.pop_front();
                    if (r !== e || int'(rot_o) !== eo) begin
                        bad++;
                        $display("FAIL %s xfer: got cycle=%0d rot=%0d, want cycle=%0d rot=%0d", tag, r, rot_o, e, eo);
                    end
                end
            end
            if (win_valid_o) begin
                total++;
                if (exp_win_rel.size() == 0) begin
                    bad++;
                    $display("FAIL %s win: unexpected window at cycle %0d", tag, r);
                end else begin
                    e  = exp_win_rel.pop_front();
                    er = exp_win_row.pop_front();
                    eo = exp_win_rot.pop_front();
                    if (r !== e || int'(win_row_o) !== er || int'(rot_o) !== eo) begin
                        bad++;
                        $display("FAIL %s win: got cycle=%0d row=%0d rot=%0d, want cycle=%0d row=%0d rot=%0d",
                                 tag, r, win_row_o, rot_o, e, er, eo);
                    end
                end
            end
            if (done_o) begin
                total++;
                if (exp_done.size() == 0) begin
                    bad++;
                    $display("FAIL %s done: unexpected done at cycle %0d", tag, r);
                end else begin
                    e = exp_done.pop_front();
                    if (r !== e) begin
                        bad++;
                        $display("FAIL %s done: got cycle=%0d, want cycle=%0d", tag, r, e);
                    end
                end
            end
            @(negedge clk);
        end
        start       = 1'b0;
        row_valid_i = 1'b0;
        abort_i     = 1'b0;
        total++;
        if (exp_xfer.size() != 0 || exp_win_rel.size() != 0 || exp_done.size() != 0) begin
            bad++;
            $display("FAIL %s missing: got leftover xfer=%0d win=%0d done=%0d, want 0 0 0",
                     tag, exp_xfer.size(), exp_win_rel.size(), exp_done.size());
            exp_xfer.delete(); exp_xrot.delete();
            exp_win_rel.delete(); exp_win_row.delete(); exp_win_rot.delete();
            exp_done.delete();
        end
    endtask

    // Expected events for an unstalled frame: transfers every GAP+1 cycles from cycle 2.
    task automatic push_plain_frame();
        for (int k = 0; k < H; k++) begin
            exp_xfer.push_back(2 + k * (GAP + 1));
            exp_xrot.push_back(k % 3);
            if (k >= 2) begin
                exp_win_rel.push_back(3 + k * (GAP + 1));
                exp_win_row.push_back(k - 2);
                exp_win_rot.push_back((k + 1) % 3);
            end
        end
        exp_done.push_back(3 + (H - 1) * (GAP + 1));
    endtask

    task automatic test_reset();
        resetn = 1'b0; start = 1'b0; row_valid_i = 1'b0; abort_i = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        total++;
        if ({row_ready_o, lb_valid_o, win_valid_o, busy_o, done_o, lb_resetn_o} !== 6'b0) begin
            bad++;
            $display("FAIL reset_flags: got rdy=%b lbv=%b win=%b busy=%b done=%b lbr=%b, want all 0",
                     row_ready_o, lb_valid_o, win_valid_o, busy_o, done_o, lb_resetn_o);
        end
        total++;
        if (win_row_o !== 8'd0 || rot_o !== 2'd0) begin
            bad++;
            $display("FAIL reset_vals: got win_row=%0d rot=%0d, want 0 0", win_row_o, rot_o);
        end
        @(negedge clk);
        resetn = 1'b1;
        #1;
        total++;
        if (lb_resetn_o !== 1'b0) begin
            bad++;
            $display("FAIL reset_lbr_hold: got %b, want 0 before first edge", lb_resetn_o);
        end
        @(negedge clk);
        #1;
        total++;
        if (lb_resetn_o !== 1'b1 || busy_o !== 1'b0) begin
            bad++;
            $display("FAIL reset_release: got lbr=%b busy=%b, want 1 0", lb_resetn_o, busy_o);
        end
        @(negedge clk);
    endtask

    task automatic test_full_frame();
        push_plain_frame();
        run_frame("full", 17, 100, 0, -1, -1);
        total++;
        if (busy_at[0] !== 1'b0 || busy_at[1] !== 1'b1 || lbr_at[1] !== 1'b0 || lbr_at[2] !== 1'b1) begin
            bad++;
            $display("FAIL full_clear: got busy0=%b busy1=%b lbr1=%b lbr2=%b, want 0 1 0 1",
                     busy_at[0], busy_at[1], lbr_at[1], lbr_at[2]);
        end
        total++;
        if (busy_at[15] !== 1'b1 || busy_at[16] !== 1'b0) begin
            bad++;
            $display("FAIL full_busy_end: got busy15=%b busy16=%b, want 1 0", busy_at[15], busy_at[16]);
        end
    endtask

    task automatic test_stall();
        int xc [5];
        xc = '{2, 5, 12, 15, 18};
        for (int k = 0; k < H; k++) begin
            exp_xfer.push_back(xc[k]);
            exp_xrot.push_back(k % 3);
            if (k >= 2) begin
                exp_win_rel.push_back(xc[k] + 1);
                exp_win_row.push_back(k - 2);
                exp_win_rot.push_back((k + 1) % 3);
            end
        end
        exp_done.push_back(19);
        run_frame("stall", 21, 6, 6, -1, -1);
        total++;
        if (rdy_at[6] !== 1'b0 || rdy_at[7] !== 1'b0 ||
            rdy_at[8] !== 1'b1 || rdy_at[9] !== 1'b1 || rdy_at[10] !== 1'b1 || rdy_at[11] !== 1'b1) begin
            bad++;
            $display("FAIL stall_hold_load: got rdy6..11=%b%b%b%b%b%b, want 001111",
                     rdy_at[6], rdy_at[7], rdy_at[8], rdy_at[9], rdy_at[10], rdy_at[11]);
        end
    endtask

    task automatic test_start_busy();
        push_plain_frame();
        run_frame("start_busy", 17, 100, 0, 3, -1);
        total++;
        if (busy_at[16] !== 1'b0) begin
            bad++;
            $display("FAIL start_busy_end: got busy16=%b, want 0", busy_at[16]);
        end
    endtask

    task automatic test_back_to_back();
        push_plain_frame();
        run_frame("b2b_first", 17, 100, 0, 15, -1);
        total++;
        if (busy_at[16] !== 1'b0 || lbr_at[16] !== 1'b1) begin
            bad++;
            $display("FAIL b2b_done_start: got busy16=%b lbr16=%b, want 0 1", busy_at[16], lbr_at[16]);
        end
        push_plain_frame();
        run_frame("b2b_second", 17, 100, 0, -1, -1);
        total++;
        if (lbr_at[1] !== 1'b0 || busy_at[1] !== 1'b1) begin
            bad++;
            $display("FAIL b2b_clear: got lbr1=%b busy1=%b, want 0 1", lbr_at[1], busy_at[1]);
        end
    endtask

    task automatic test_async_reset();
        for (int r = 0; r < 13; r++) begin
            start       = (r == 0);
            row_valid_i = 1'b1;
            @(negedge clk);
        end
        #1;
        total++;
        if (win_row_o !== 8'd1 || rot_o !== 2'd1 || busy_o !== 1'b1) begin
            bad++;
            $display("FAIL areset_pre: got win_row=%0d rot=%0d busy=%b, want 1 1 1", win_row_o, rot_o, busy_o);
        end
        resetn = 1'b0;
        #1;
        total++;
        if (busy_o !== 1'b0 || rot_o !== 2'd0 || win_row_o !== 8'd0 || lb_resetn_o !== 1'b0 || row_ready_o !== 1'b0) begin
            bad++;
            $display("FAIL areset_now: got busy=%b rot=%0d win_row=%0d lbr=%b rdy=%b, want 0 0 0 0 0",
                     busy_o, rot_o, win_row_o, lb_resetn_o, row_ready_o);
        end
        @(negedge clk);
        resetn = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        total++;
        if (busy_o !== 1'b0 || lb_valid_o !== 1'b0) begin
            bad++;
            $display("FAIL areset_needs_start: got busy=%b lbv=%b, want 0 0", busy_o, lb_valid_o);
        end
        row_valid_i = 1'b0;
        @(negedge clk);
    endtask

`ifdef LB_CTRL_ABORT_EN
    task automatic test_abort();
        exp_xfer.push_back(2); exp_xrot.push_back(0);
        exp_xfer.push_back(5); exp_xrot.push_back(1);
        run_frame("abort", 12, 100, 0, -1, 8);
        total++;
        if (busy_at[8] !== 1'b1 || busy_at[9] !== 1'b0 || lbr_at[9] !== 1'b0 || lbr_at[10] !== 1'b1) begin
            bad++;
            $display("FAIL abort_exit: got busy8=%b busy9=%b lbr9=%b lbr10=%b, want 1 0 0 1",
                     busy_at[8], busy_at[9], lbr_at[9], lbr_at[10]);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_full_frame();
        test_stall();
        test_start_busy();
        test_back_to_back();
`ifdef LB_CTRL_ABORT_EN
        test_abort();
`endif
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
